// File: rtl/somador_subtrator_serial.sv
// Digit-serial adder/subtractor: one WIDTH-bit operand pair per handshake, DIGIT bits per clock,
// with the carry held in a register between digits; result held in DONE until out_ready.
module somador_subtrator_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_param
      $error("somador_subtrator_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dig_sum;
  logic             c_into_msb;
  logic             last_dig;
  logic             accept;

  // Operands shift right one digit per CALC edge, so the active digit is always at the bottom.
  assign a_dig      = a_q[DIGIT-1:0];
  assign b_dig      = b_q[DIGIT-1:0];
  assign dig_sum    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  // Carry into the top bit of this digit, recovered from the top sum bit and its operands.
  assign c_into_msb = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_sum[DIGIT-1];
  assign last_dig   = (idx_q == IW'(N - 1));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (last_dig) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      s        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub;
        idx_q   <= '0;
      end else if (state_q == CALC) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        carry_q <= dig_sum[DIGIT];
        idx_q   <= idx_q + IW'(1);
        s[idx_q*DIGIT +: DIGIT] <= dig_sum[DIGIT-1:0];
        if (last_dig) begin
          cout     <= dig_sum[DIGIT];
          overflow <= c_into_msb ^ dig_sum[DIGIT];
        end
      end
    end
  end

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Bench for somador_subtrator_serial: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit instance.
module tb_somador_subtrator_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv8, ir8, ov8, or8, sub8, c8, o8;
  logic [7:0]  a8, b8, s8;
  logic        iv16, ir16, ov16, or16, sub16, c16, o16;
  logic [15:0] a16, b16, s16;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  somador_subtrator_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .s(s8), .cout(c8), .overflow(o8)
  );

  somador_subtrator_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16), .s(s16), .cout(c16), .overflow(o16)
  );

  // Whole-word reference: sum at width w, carry into the MSB from the low w-1 bits.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub);
    logic [16:0] full, low;
    logic [15:0] mask, bb;
    exp_t        e;
    mask = 16'((17'd1 << w) - 17'd1);
    bb   = (sub ? ~b : b) & mask;
    full = {1'b0, a & mask} + {1'b0, bb} + 17'(sub);
    low  = {1'b0, a & (mask >> 1)} + {1'b0, bb & (mask >> 1)} + 17'(sub);
    e.s  = full[15:0] & mask;
    e.c  = full[w];
    e.o  = low[w-1] ^ full[w];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sub);
    a8 = a; b8 = b; sub8 = sub; iv8 = 1'b1;
    tick();
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sub);
    a16 = a; b16 = b; sub16 = sub; iv16 = 1'b1;
    tick();
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
  endtask

  task automatic wait_out8(output int cyc);
    cyc = 0;
    while (ov8 !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_out16(output int cyc);
    cyc = 0;
    while (ov16 !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic retire8();
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
  endtask

  task automatic retire16();
    or16 = 1'b1;
    tick();
    or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({ir8, ov8, s8, c8, o8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset8 got ir=%b ov=%b s=%h c=%b o=%b want ir=1 ov=0 s=00 c=0 o=0",
               ir8, ov8, s8, c8, o8);
    end
    total++;
    if ({ir16, ov16, s16, c16, o16} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset16 got ir=%b ov=%b s=%h c=%b o=%b want ir=1 ov=0 s=0000 c=0 o=0",
               ir16, ov16, s16, c16, o16);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Directed 8-bit op: latency must be exactly 8 and result must match the given constants.
  task automatic directed8(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic sub, input logic [7:0] es, input logic ec, input logic eo);
    int   cyc;
    exp_t e;
    q8.push_back('{s: {8'h00, es}, c: ec, o: eo});
    issue8(a, b, sub);
    wait_out8(cyc);
    total++;
    if (cyc !== 8) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=8", name, cyc);
    end
    e = q8.pop_front();
    total++;
    if ({s8, c8, o8} !== {e.s[7:0], e.c, e.o}) begin
      bad++;
      $display("FAIL %s got s=%h c=%b o=%b want s=%h c=%b o=%b", name, s8, c8, o8, e.s[7:0], e.c, e.o);
    end
    retire8();
    total++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      bad++;
      $display("FAIL %s_retire got ov=%b ir=%b want ov=0 ir=1", name, ov8, ir8);
    end
  endtask

  task automatic test_add();
    directed8("add_200_100", 8'd200, 8'd100, 1'b0, 8'h2C, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    directed8("sub_5_7", 8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0);
    directed8("sub_7_5", 8'd7, 8'd5, 1'b1, 8'h02, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    directed8("ovf_add", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    directed8("ovf_sub", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_hold();
    int   cyc;
    exp_t e;
    q8.push_back('{s: 16'h0077, c: 1'b0, o: 1'b0});
    issue8(8'h33, 8'h44, 1'b0);
    wait_out8(cyc);
    total++;
    if (cyc !== 8) begin
      bad++;
      $display("FAIL hold_latency got=%0d want=8", cyc);
    end
    e = q8.pop_front();
    or8 = 1'b0; iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({ov8, ir8, s8, c8, o8} !== {1'b1, 1'b0, e.s[7:0], e.c, e.o}) begin
        bad++;
        $display("FAIL hold_cycle%0d got ov=%b ir=%b s=%h c=%b o=%b want ov=1 ir=0 s=%h c=%b o=%b",
                 i, ov8, ir8, s8, c8, o8, e.s[7:0], e.c, e.o);
      end
    end
    // in_valid is still high across the retiring edge; it must not be taken.
    retire8();
    total++;
    if ({ov8, ir8, s8} !== {1'b0, 1'b1, e.s[7:0]}) begin
      bad++;
      $display("FAIL hold_retire got ov=%b ir=%b s=%h want ov=0 ir=1 s=%h", ov8, ir8, s8, e.s[7:0]);
    end
    iv8 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_calc();
    issue8(8'hAA, 8'h55, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({ov8, ir8, s8} !== {1'b0, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL midcalc_reset got ov=%b ir=%b s=%h want ov=0 ir=1 s=00", ov8, ir8, s8);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (ov8 !== 1'b0) begin
      bad++;
      $display("FAIL midcalc_no_result got ov=%b want ov=0", ov8);
    end
    directed8("after_reset", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
  endtask

  task automatic test_wide();
    int   cyc;
    exp_t e;
    q16.push_back('{s: 16'h0000, c: 1'b1, o: 1'b0});
    issue16(16'hFFFF, 16'h0001, 1'b0);
    wait_out16(cyc);
    total++;
    if (cyc !== 4) begin
      bad++;
      $display("FAIL wide_latency got=%0d want=4", cyc);
    end
    e = q16.pop_front();
    total++;
    if ({s16, c16, o16} !== {e.s, e.c, e.o}) begin
      bad++;
      $display("FAIL wide got s=%h c=%b o=%b want s=%h c=%b o=%b", s16, c16, o16, e.s, e.c, e.o);
    end
    retire16();
  endtask

  task automatic test_back_to_back();
    int          cyc;
    exp_t        e;
    logic [15:0] ra, rb;
    logic        rs;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      if (i < 4) begin
        ra = (i[0]) ? 16'h8000 : 16'h7FFF;
        rb = (i[1]) ? 16'hFFFF : 16'h0001;
      end
      total++;
      if (ir16 !== 1'b1) begin
        bad++;
        $display("FAIL b2b16_ready vec=%0d got ir=%b want ir=1", i, ir16);
      end
      q16.push_back(model(16, ra, rb, rs));
      issue16(ra, rb, rs);
      wait_out16(cyc);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      e = q16.pop_front();
      total++;
      if (cyc !== 4 || {s16, c16, o16} !== {e.s, e.c, e.o}) begin
        bad++;
        $display("FAIL b2b16 vec=%0d a=%h b=%h sub=%b got lat=%0d s=%h c=%b o=%b want lat=4 s=%h c=%b o=%b",
                 i, ra, rb, rs, cyc, s16, c16, o16, e.s, e.c, e.o);
      end
      retire16();
    end
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255)); rs = 1'($urandom);
      q8.push_back(model(8, ra, rb, rs));
      issue8(ra[7:0], rb[7:0], rs);
      wait_out8(cyc);
      e = q8.pop_front();
      total++;
      if (cyc !== 8 || {s8, c8, o8} !== {e.s[7:0], e.c, e.o}) begin
        bad++;
        $display("FAIL b2b8 vec=%0d a=%h b=%h sub=%b got lat=%0d s=%h c=%b o=%b want lat=8 s=%h c=%b o=%b",
                 i, ra[7:0], rb[7:0], rs, cyc, s8, c8, o8, e.s[7:0], e.c, e.o);
      end
      retire8();
    end
  endtask

  initial begin
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_hold();
    test_reset_mid_calc();
    test_wide();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
